// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 sync timing and the lock FSM encoding shared by the
// VGA sync decoder files.
package vga_timing_pkg;

  localparam int H_TOTAL  = 800;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 525;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Raw active-low HS/VS pair as driven by a VGA source and seen by the decoder.
interface vga_sync_decoder_if;

  logic hs;
  logic vs;

  modport master (output hs, output vs);
  modport slave  (input hs, input vs);

endinterface

// File: rtl/vga_sync_edge.sv
// Two-flop synchronizer for an asynchronous active-low sync pin, plus a
// one-cycle pulse on its synchronized falling edge.
module vga_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops idle high so a pin already low after reset reads as a fresh edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers beam position, blanking and lock from an incoming HS/VS pair.
// Optional VGA_SYNC_STATS_EN adds line_len/frame_lines measurement outputs.
module vga_sync_decoder
  import vga_timing_pkg::sync_state_e;
  import vga_timing_pkg::SEARCH;
  import vga_timing_pkg::MEASURE;
  import vga_timing_pkg::LOCKED;
#(
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BACK      = vga_timing_pkg::H_BACK,
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BACK      = vga_timing_pkg::V_BACK,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       HS,
  input  logic       VS,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       blank,
  output logic       locked,
  output logic       frame_start
`ifdef VGA_SYNC_STATS_EN
  ,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines
`endif
);

  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  logic        hs_fall;
  logic        vs_fall;
  logic        frame_evt;
  logic        bad_line;
  logic        bad_frame;
  logic        timeout;
  logic        h_act;
  logic        v_act;

  sync_state_e state_q, state_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        vs_pend_q, vs_pend_d;
  logic        first_q, first_d;
  logic [7:0]  good_q, good_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        blank_q, blank_d;
  logic        locked_q;
  logic        frame_start_q;

  vga_sync_edge u_hs_edge (.clk_i(CLK), .rst_ni(RESETN), .async_i(HS), .fall_o(hs_fall));
  vga_sync_edge u_vs_edge (.clk_i(CLK), .rst_ni(RESETN), .async_i(VS), .fall_o(vs_fall));

  // A VS edge only arms the frame; the frame begins on the following HS edge.
  assign frame_evt = hs_fall & vs_pend_q;
  assign bad_line  = hs_fall & ~first_q & (hcnt_q != H_LAST);
  assign bad_frame = frame_evt & (vcnt_q != V_LAST);
  assign timeout   = (hcnt_q == CNT_MAX);
  assign h_act     = (hcnt_q >= H_START) && (hcnt_q <= H_END);
  assign v_act     = (vcnt_q >= V_START) && (vcnt_q <= V_END);

  // Pixel/line counters and the pending-frame flag.
  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    vs_pend_d = vs_pend_q;
    if (hs_fall) begin
      hcnt_d = 10'd0;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 10'd1;
    end else begin
      hcnt_d = hcnt_q;
    end
    if (frame_evt) begin
      vcnt_d = 10'd0;
    end else if (hs_fall && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end else begin
      vcnt_d = vcnt_q;
    end
    if (vs_fall) begin
      vs_pend_d = 1'b1;
    end else if (frame_evt) begin
      vs_pend_d = 1'b0;
    end else begin
      vs_pend_d = vs_pend_q;
    end
  end

  // Lock FSM: search for a frame start, count good frames, hold while clean.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (frame_evt) begin
          state_d = MEASURE;
          good_d  = 8'd0;
        end else begin
          state_d = SEARCH;
        end
      end
      MEASURE: begin
        if (bad_line || bad_frame || timeout) begin
          state_d = SEARCH;
        end else if (frame_evt) begin
          good_d = good_q + 8'd1;
          if ((good_q + 8'd1) == LOCK_N) begin
            state_d = LOCKED;
          end else begin
            state_d = MEASURE;
          end
        end else begin
          state_d = MEASURE;
        end
      end
      LOCKED: begin
        if (bad_line || bad_frame || timeout) begin
          state_d = SEARCH;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = SEARCH;
    endcase
    // The line in progress when SEARCH is entered has an unknown start.
    if ((state_q != SEARCH) && (state_d == SEARCH)) begin
      first_d = 1'b1;
    end else if (hs_fall) begin
      first_d = 1'b0;
    end else begin
      first_d = first_q;
    end
  end

  // Position and blanking outputs.
  always_comb begin
    blank_d = 1'b1;
    x_d     = 10'd0;
    y_d     = 10'd0;
    if (locked_q && h_act && v_act) begin
      blank_d = 1'b0;
      x_d     = hcnt_q - H_START;
      y_d     = vcnt_q - V_START;
    end else begin
      blank_d = 1'b1;
      x_d     = 10'd0;
      y_d     = 10'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= SEARCH;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      vs_pend_q     <= 1'b0;
      first_q       <= 1'b1;
      good_q        <= 8'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      blank_q       <= 1'b1;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      vs_pend_q     <= vs_pend_d;
      first_q       <= first_d;
      good_q        <= good_d;
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      locked_q      <= (state_d == LOCKED);
      frame_start_q <= frame_evt;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign blank       = blank_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_STATS_EN
  logic [9:0] line_len_q;
  logic [9:0] frame_lines_q;

  // Measured line length and frame height from the last completed period.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      line_len_q    <= 10'd0;
      frame_lines_q <= 10'd0;
    end else begin
      line_len_q    <= hs_fall   ? hcnt_q : line_len_q;
      frame_lines_q <= frame_evt ? vcnt_q : frame_lines_q;
    end
  end

  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder driven by a small VGA-style source
// (scaled timing: 40 clocks per line, 20 lines per frame).
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int HSY = 4;
  localparam int HBK = 4;
  localparam int HAC = 24;
  localparam int VT  = 20;
  localparam int VSY = 2;
  localparam int VBK = 3;
  localparam int VAC = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x;
  logic [9:0] y;
  logic       blank;
  logic       locked;
  logic       frame_start;
`ifdef VGA_SYNC_STATS_EN
  logic [9:0] line_len;
  logic [9:0] frame_lines;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Source position of the next pixel to drive, plus per-line/frame overrides.
  int sh, sv, frm;
  int short_line  = -1;
  int short_frame = -1;
  int hq[4];
  int vq[4];
  int fq[4];

  vga_sync_decoder_if sync_if ();

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HSY), .H_BACK(HBK), .H_ACTIVE(HAC),
    .V_TOTAL(VT), .V_SYNC(VSY), .V_BACK(VBK), .V_ACTIVE(VAC),
    .LOCK_FRAMES(2)
  ) dut (
    .CLK(clk),
    .RESETN(rst_n),
    .HS(sync_if.hs),
    .VS(sync_if.vs),
    .x(x),
    .y(y),
    .blank(blank),
    .locked(locked),
    .frame_start(frame_start)
`ifdef VGA_SYNC_STATS_EN
    ,
    .line_len(line_len),
    .frame_lines(frame_lines)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic hs, input logic vs);
    sync_if.hs = hs;
    sync_if.vs = vs;
    @(posedge clk);
    #1;
  endtask

  // VS follows the line that begins at the next HS edge, so it falls one
  // pixel ahead of the HS edge that opens line 0.
  task automatic src_step();
    int hlen, vlen, nv;
    hlen = (sv == short_line) ? HT - 1 : HT;
    vlen = (frm == short_frame) ? VT - 1 : VT;
    nv   = (sh == hlen - 1) ? ((sv == vlen - 1) ? 0 : sv + 1) : sv;
    for (int i = 3; i > 0; i--) begin
      hq[i] = hq[i-1];
      vq[i] = vq[i-1];
      fq[i] = fq[i-1];
    end
    hq[0] = sh;
    vq[0] = sv;
    fq[0] = frm;
    tick(sh >= HSY, nv >= VSY);
    if (sh == hlen - 1) begin
      sh = 0;
      if (sv == short_line) short_line = -1;
      if (sv == vlen - 1) begin
        sv = 0;
        frm++;
      end else begin
        sv++;
      end
    end else begin
      sh++;
    end
  endtask

  // Advance until the pixel driven 'lag' steps ago is (f, v, h).
  task automatic run_until(input int lag, input int f, input int v, input int h);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      src_step();
      found = (fq[lag] == f) && (vq[lag] == v) && (hq[lag] == h);
    end
    check($sformatf("reach_%0d_%0d_%0d", f, v, h), {31'd0, found}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      hq[i] = -1;
      vq[i] = -1;
      fq[i] = -1;
    end
    sh  = 0;
    sv  = VT - 1;
    frm = 0;
    rst_n = 1'b0;
    repeat (3) tick(1'b1, 1'b1);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_blank", blank, 1);
    check("rst_locked", locked, 0);
    check("rst_fs", frame_start, 0);
    rst_n = 1'b1;

    // Acquisition: frame 1 start enters MEASURE, frame 3 start locks.
    run_until(2, 1, 0, 0);
    check("fs_f1", frame_start, 1);
    check("lock_f1", locked, 0);
    src_step();
    check("fs_pulse_end", frame_start, 0);
    run_until(2, 2, 0, 0);
    check("fs_f2", frame_start, 1);
    check("lock_f2", locked, 0);
`ifdef VGA_SYNC_STATS_EN
    check("line_len", line_len, HT - 1);
    check("frame_lines", frame_lines, VT - 1);
`endif
    run_until(2, 2, VT - 1, HT - 1);
    check("lock_pre_f3", locked, 0);
    src_step();
    check("lock_f3", locked, 1);
    run_until(3, 3, 5, 7);
    check("blank_h7", blank, 1);
    src_step();
    check("first_x", x, 0);
    check("first_y", y, 0);
    check("first_blank", blank, 0);
    run_until(3, 3, 10, 20);
    check("mid_x", x, 12);
    check("mid_y", y, 5);
    run_until(3, 3, 16, 31);
    check("last_x", x, 23);
    check("last_y", y, 11);
    check("last_blank", blank, 0);
    src_step();
    check("past_last_blank", blank, 1);
    check("past_last_x", x, 0);

    // A 39-clock line 10 in frame 4 breaks lock at the next HS edge.
    short_line = 10;
    run_until(2, 4, 10, 38);
    check("lock_pre_bad", locked, 1);
    src_step();
    check("lock_bad_line", locked, 0);
    run_until(3, 4, 11, 10);
    check("blank_unlocked", blank, 1);
    check("x_unlocked", x, 0);
    run_until(2, 6, 0, 0);
    check("relock_f6", locked, 0);
    run_until(2, 7, 0, 0);
    check("relock_f7", locked, 1);

    // A 19-line frame 8 breaks lock at frame 9 start; MEASURE from frame 10.
    short_frame = 8;
    run_until(2, 8, VT - 2, HT - 1);
    check("lock_pre_short", locked, 1);
    src_step();
    check("lock_short_frame", locked, 0);
    check("fs_short_frame", frame_start, 1);
    run_until(2, 11, 0, 0);
    check("short_relock_f11", locked, 0);
    run_until(2, 12, 0, 0);
    check("short_relock_f12", locked, 1);

    // Asynchronous reset mid-frame, with no clock edge before the check.
    run_until(0, 12, 10, 20);
    check("pre_rst_blank", blank, 0);
    check("pre_rst_x", x, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_x", x, 0);
    check("arst_y", y, 0);
    check("arst_blank", blank, 1);
    check("arst_locked", locked, 0);
    check("arst_fs", frame_start, 0);
    src_step();
    src_step();
    rst_n = 1'b1;
    run_until(2, 14, 0, 0);
    check("arst_relock_f14", locked, 0);
    run_until(2, 15, 0, 0);
    check("arst_relock_f15", locked, 1);

    // HS stuck high: hcnt saturates at 1023 and lock drops one clock later.
    run_until(0, 15, 3, 0);
    repeat (HT - 1) src_step();
    repeat (986) tick(1'b1, 1'b1);
    check("lock_pre_timeout", locked, 1);
    tick(1'b1, 1'b1);
    check("lock_timeout", locked, 0);
    check("blank_timeout", blank, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
